// File: rtl/bapple_player.sv
// Block-graphics frame player: streams one ROWS x COLS bitmap per frame out of
// a synchronous ROM into a back buffer and swaps it to the display on vsync.
module bapple_player #(
    parameter int          HPIXELS    = 640,
    parameter int          VPIXELS    = 480,
    parameter int          BLOCK_SIZE = 16,
    parameter int          NUM_FRAMES = 3286,
    parameter int          FRAME_DIV  = 6,
    parameter logic [11:0] FG_COLOR   = 12'hFFF,
    parameter logic [11:0] BG_COLOR   = 12'h000,
    localparam int         COLS       = HPIXELS / BLOCK_SIZE,
    localparam int         ROWS       = VPIXELS / BLOCK_SIZE,
    localparam int         FN_W       = $clog2(NUM_FRAMES),
    localparam int         AW         = $clog2(NUM_FRAMES * ROWS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            vsync,
    input  logic [9:0]      hc,
    input  logic [9:0]      vc,
    input  logic            play_toggle,
    input  logic            step,
    input  logic            reverse,
    input  logic            loop_en,
    output logic [AW-1:0]   rom_addr,
    input  logic [COLS-1:0] rom_data,
    output logic [3:0]      red,
    output logic [3:0]      green,
    output logic [3:0]      blue,
    output logic [FN_W-1:0] frame_num,
    output logic            playing,
    output logic            busy
);

    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int FC_W  = $clog2(ROWS + 1);
    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    localparam logic [FN_W-1:0]  LAST_FRAME = FN_W'(NUM_FRAMES - 1);
    localparam logic [AW-1:0]    ROWS_A     = AW'(ROWS);
    localparam logic [FC_W-1:0]  FC_LAST    = FC_W'(ROWS);
    localparam logic [FC_W-1:0]  FC_ADDR_END = FC_W'(ROWS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(FRAME_DIV - 1);
    localparam logic [9:0]       H_LIM      = 10'(HPIXELS);
    localparam logic [9:0]       V_LIM      = 10'(VPIXELS);
    localparam logic [9:0]       BLK        = 10'(BLOCK_SIZE);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FETCH     = 2'd1,
        WAIT_SWAP = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic              vsync_prev_r;
    logic              vedge_s, tick_s, step_ok_s;
    logic              start_s, stop_s, swap_s, wr_en_s;
    logic              calc_stop_s;
    logic [FN_W-1:0]   calc_target_s;
    logic [DIV_W-1:0]  div_r;
    logic [FN_W-1:0]   frame_num_r, target_r;
    logic              playing_r, busy_r, front_sel_r;
    logic [FC_W-1:0]   fcnt_r;
    logic [AW-1:0]     rom_addr_r;
    logic [COLS-1:0]   buf0_r [ROWS];
    logic [COLS-1:0]   buf1_r [ROWS];
    logic [RW-1:0]     wr_row_s, pix_row_s;
    logic [CW-1:0]     pix_col_s;
    logic              in_view_s, pix_bit_s;
    logic [11:0]       rgb_r;

    assign vedge_s   = vsync & ~vsync_prev_r;
    assign tick_s    = vedge_s & playing_r & (div_r == DIV_LAST);
    // A toggle in the same cycle wins over a step; steps only act while paused.
    assign step_ok_s = step & ~playing_r & ~play_toggle;
    assign wr_row_s  = RW'(fcnt_r - FC_W'(1));

    // Next frame to load given direction and end-of-clip handling.
    always_comb begin
        calc_target_s = frame_num_r;
        calc_stop_s   = 1'b0;
        if (reverse) begin
            if (frame_num_r == {FN_W{1'b0}}) begin
                if (loop_en) begin
                    calc_target_s = LAST_FRAME;
                end else begin
                    calc_stop_s = 1'b1;
                end
            end else begin
                calc_target_s = frame_num_r - FN_W'(1);
            end
        end else begin
            if (frame_num_r == LAST_FRAME) begin
                if (loop_en) begin
                    calc_target_s = {FN_W{1'b0}};
                end else begin
                    calc_stop_s = 1'b1;
                end
            end else begin
                calc_target_s = frame_num_r + FN_W'(1);
            end
        end
    end

    // Load sequencer next-state and control strobes.
    always_comb begin
        state_s = state_r;
        start_s = 1'b0;
        stop_s  = 1'b0;
        swap_s  = 1'b0;
        wr_en_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (tick_s | step_ok_s) begin
                    if (calc_stop_s) begin
                        stop_s = 1'b1;
                    end else begin
                        start_s = 1'b1;
                        state_s = FETCH;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: begin
                // Row r arrives one cycle after its address, so writes lag by one.
                wr_en_s = (fcnt_r != {FC_W{1'b0}});
                if (fcnt_r == FC_LAST) begin
                    state_s = WAIT_SWAP;
                end else begin
                    state_s = FETCH;
                end
            end
            WAIT_SWAP: begin
                if (vedge_s) begin
                    swap_s  = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_SWAP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register; reset starts an immediate load of frame 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= FETCH;
            busy_r  <= 1'b1;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != IDLE);
        end
    end

    // Play state, frame divider, displayed frame and buffer selection.
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_prev_r <= 1'b0;
            playing_r    <= 1'b0;
            div_r        <= {DIV_W{1'b0}};
            frame_num_r  <= {FN_W{1'b0}};
            target_r     <= {FN_W{1'b0}};
            front_sel_r  <= 1'b0;
        end else begin
            vsync_prev_r <= vsync;
            playing_r    <= stop_s ? 1'b0 : (playing_r ^ play_toggle);
            if (stop_s) begin
                div_r <= {DIV_W{1'b0}};
            end else if (vedge_s & playing_r) begin
                div_r <= (div_r == DIV_LAST) ? {DIV_W{1'b0}} : div_r + DIV_W'(1);
            end
            if (start_s) begin
                target_r <= calc_target_s;
            end
            if (swap_s) begin
                frame_num_r <= target_r;
                front_sel_r <= ~front_sel_r;
            end
        end
    end

    // ROM address walk and row counter for the current load.
    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt_r     <= {FC_W{1'b0}};
            rom_addr_r <= {AW{1'b0}};
        end else if (start_s) begin
            fcnt_r     <= {FC_W{1'b0}};
            rom_addr_r <= AW'(calc_target_s) * ROWS_A;
        end else if (state_r == FETCH) begin
            if (fcnt_r != FC_LAST) begin
                fcnt_r <= fcnt_r + FC_W'(1);
            end
            if (fcnt_r < FC_ADDR_END) begin
                rom_addr_r <= rom_addr_r + AW'(1);
            end
        end
    end

    // Back-buffer row writes; the back buffer is whichever one is not displayed.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROWS; i++) begin
                buf0_r[i] <= {COLS{1'b0}};
                buf1_r[i] <= {COLS{1'b0}};
            end
        end else if (wr_en_s) begin
            if (front_sel_r) begin
                buf0_r[wr_row_s] <= rom_data;
            end else begin
                buf1_r[wr_row_s] <= rom_data;
            end
        end
    end

    // Map the beam position to a block of the front buffer.
    always_comb begin
        in_view_s = (hc < H_LIM) && (vc < V_LIM);
        pix_row_s = RW'(vc / BLK);
        pix_col_s = CW'(hc / BLK);
        pix_bit_s = 1'b0;
        if (in_view_s) begin
            pix_bit_s = front_sel_r ? buf1_r[pix_row_s][pix_col_s]
                                    : buf0_r[pix_row_s][pix_col_s];
        end else begin
            pix_bit_s = 1'b0;
        end
    end

    // Registered pixel colour, blank outside the visible area.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_r <= 12'h000;
        end else if (!in_view_s) begin
            rgb_r <= 12'h000;
        end else begin
            rgb_r <= pix_bit_s ? FG_COLOR : BG_COLOR;
        end
    end

    assign rom_addr  = rom_addr_r;
    assign red       = rgb_r[11:8];
    assign green     = rgb_r[7:4];
    assign blue      = rgb_r[3:0];
    assign frame_num = frame_num_r;
    assign playing   = playing_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_bapple_player.sv
// Directed bench for bapple_player with default parameters (40x30 blocks).
module tb_bapple_player;

    logic        clk = 1'b0;
    logic        rst;
    logic        vsync;
    logic [9:0]  hc, vc;
    logic        play_toggle, step, reverse, loop_en;
    logic [16:0] rom_addr;
    logic [39:0] rom_data;
    logic [3:0]  red, green, blue;
    logic [11:0] frame_num;
    logic        playing, busy;
    logic [11:0] rgb_s;

    int n_checks = 0;
    int n_fail   = 0;

    bapple_player dut (
        .clk(clk), .rst(rst), .vsync(vsync), .hc(hc), .vc(vc),
        .play_toggle(play_toggle), .step(step), .reverse(reverse), .loop_en(loop_en),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .red(red), .green(green), .blue(blue),
        .frame_num(frame_num), .playing(playing), .busy(busy)
    );

    assign rgb_s = {red, green, blue};

    always #5 clk = ~clk;

    // ROM contents: frame 0 row 0 all ones, otherwise bit c = ((f+r+c) % 3 == 0).
    function automatic logic [39:0] rom_fn(input logic [16:0] a);
        int f;
        int r;
        logic [39:0] d;
        f = int'(a) / 30;
        r = int'(a) % 30;
        d = {40{1'b0}};
        for (int c = 0; c < 40; c++) d[c] = (((f + r + c) % 3) == 0);
        if (f == 0 && r == 0) d = {40{1'b1}};
        return d;
    endfunction

    // Synchronous ROM model: one cycle address-to-data latency.
    always_ff @(posedge clk) rom_data <= rom_fn(rom_addr);

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic vpulse();
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_step();
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
    endtask

    task automatic pulse_toggle();
        play_toggle = 1'b1;
        @(negedge clk);
        play_toggle = 1'b0;
    endtask

    task automatic pix_check(input string tag, input logic [9:0] h, input logic [9:0] v,
                             input logic [11:0] exp);
        hc = h;
        vc = v;
        @(negedge clk);
        check_eq(tag, rgb_s, exp);
    endtask

    // Step paused playback forward by one frame and swap it in.
    task automatic step_frame();
        pulse_step();
        cyc(35);
        vpulse();
    endtask

    initial begin
        rst = 1'b1; vsync = 1'b0; hc = 10'd0; vc = 10'd0;
        play_toggle = 1'b0; step = 1'b0; reverse = 1'b0; loop_en = 1'b0;
        cyc(3);
        check_eq("rst_frame", frame_num, 12'd0);
        check_eq("rst_playing", playing, 1'b0);
        check_eq("rst_busy", busy, 1'b1);
        check_eq("rst_rgb", rgb_s, 12'h000);
        check_eq("rst_addr", rom_addr, 17'd0);

        // Initial load of frame 0 after reset release.
        rst = 1'b0;
        cyc(1);
        check_eq("init_addr1", rom_addr, 17'd1);
        cyc(9);
        vpulse();                               // edge during FETCH: no swap
        pix_check("init_pix_bg", 10'd0, 10'd0, 12'h000);
        cyc(16);
        check_eq("init_addr29", rom_addr, 17'd29);
        cyc(2);
        check_eq("init_addr_hold", rom_addr, 17'd29);
        check_eq("init_busy_wait", busy, 1'b1);
        vpulse();
        check_eq("init_busy_done", busy, 1'b0);
        check_eq("init_frame", frame_num, 12'd0);
        pix_check("pix_00", 10'd0, 10'd0, 12'hFFF);
        pix_check("pix_h640", 10'd640, 10'd0, 12'h000);
        pix_check("pix_v480", 10'd0, 10'd480, 12'h000);
        pix_check("pix_31_479", 10'd31, 10'd479, 12'hFFF);
        pix_check("pix_639_16", 10'd639, 10'd16, 12'h000);
        pix_check("pix_623_16", 10'd623, 10'd16, 12'hFFF);
        vpulse();
        vpulse();
        check_eq("idle_frame", frame_num, 12'd0);
        check_eq("idle_busy", busy, 1'b0);

        // Playing with divide-by-6.
        pulse_toggle();
        check_eq("play_on", playing, 1'b1);
        for (int e = 1; e <= 13; e++) begin
            vpulse();
            if (e == 5) begin
                check_eq("e5_busy", busy, 1'b0);
                check_eq("e5_frame", frame_num, 12'd0);
            end
            if (e == 6) check_eq("e6_busy", busy, 1'b1);
            if (e == 7) check_eq("e7_frame", frame_num, 12'd1);
            if (e == 12) begin
                check_eq("e12_busy", busy, 1'b1);
                check_eq("e12_frame", frame_num, 12'd1);
            end
            if (e == 13) check_eq("e13_frame", frame_num, 12'd2);
            cyc(35);
        end
        pulse_toggle();                         // divider left at 1
        check_eq("play_off", playing, 1'b0);
        pix_check("f2_pix_00", 10'd0, 10'd0, 12'h000);
        pix_check("f2_pix_16", 10'd16, 10'd0, 12'hFFF);

        // Stepping while paused; second step during busy is dropped.
        for (int i = 0; i < 3; i++) step_frame();
        check_eq("step_f5", frame_num, 12'd5);
        pulse_step();
        @(negedge clk);
        pulse_step();
        check_eq("step2_busy", busy, 1'b1);
        cyc(35);
        vpulse();
        check_eq("step_f6", frame_num, 12'd6);
        check_eq("step_idle", busy, 1'b0);
        check_eq("step_addr", rom_addr, 17'd209);
        vpulse();
        check_eq("step_noqueue", frame_num, 12'd6);

        // Reset in the middle of a fetch.
        for (int i = 0; i < 34; i++) step_frame();
        check_eq("f40", frame_num, 12'd40);
        pulse_step();
        check_eq("f41_addr0", rom_addr, 17'd1230);
        pulse_toggle();
        check_eq("mid_playing", playing, 1'b1);
        cyc(3);
        check_eq("f41_addr4", rom_addr, 17'd1234);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mrst_frame", frame_num, 12'd0);
        check_eq("mrst_playing", playing, 1'b0);
        check_eq("mrst_addr", rom_addr, 17'd0);
        check_eq("mrst_rgb", rgb_s, 12'h000);
        rst = 1'b0;
        cyc(2);
        check_eq("mrst_addr2", rom_addr, 17'd2);
        cyc(32);
        vpulse();
        check_eq("mrst_reload", frame_num, 12'd0);
        pix_check("mrst_pix", 10'd0, 10'd0, 12'hFFF);

        // Reverse wrap from frame 0.
        reverse = 1'b1;
        loop_en = 1'b1;
        pulse_toggle();
        for (int e = 1; e <= 5; e++) vpulse();
        check_eq("rev_e5_busy", busy, 1'b0);
        vsync = 1'b1;
        @(negedge clk);
        check_eq("rev_addr0", rom_addr, 17'd98550);
        check_eq("rev_busy", busy, 1'b1);
        vsync = 1'b0;
        @(negedge clk);
        check_eq("rev_addr1", rom_addr, 17'd98551);
        cyc(35);
        vpulse();                               // divider now 1
        check_eq("rev_frame", frame_num, 12'd3285);
        pix_check("rev_pix_00", 10'd0, 10'd0, 12'hFFF);
        pix_check("rev_pix_16", 10'd16, 10'd0, 12'h000);
        pulse_toggle();

        // Forward end with loop disabled, then enabled.
        reverse = 1'b0;
        loop_en = 1'b0;
        pulse_toggle();
        for (int e = 1; e <= 4; e++) vpulse();
        check_eq("end_e4_playing", playing, 1'b1);
        vpulse();
        check_eq("end_stop_playing", playing, 1'b0);
        check_eq("end_stop_frame", frame_num, 12'd3285);
        check_eq("end_stop_busy", busy, 1'b0);
        vpulse();
        check_eq("end_stop_hold", frame_num, 12'd3285);
        loop_en = 1'b1;
        pulse_toggle();
        for (int e = 1; e <= 5; e++) vpulse();
        check_eq("wrap_e5_busy", busy, 1'b0);
        vsync = 1'b1;
        @(negedge clk);
        check_eq("wrap_addr0", rom_addr, 17'd0);
        vsync = 1'b0;
        cyc(36);
        vpulse();
        check_eq("wrap_frame", frame_num, 12'd0);
        check_eq("wrap_playing", playing, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
